arb_grant_capture: RTL
======================

# arb_grant_capture

Downstream consumer of the 3-way fixed-priority arbiter's registered one-hot grant. It captures one data word from the granted source per grant episode, tags the word with its source ID, and buffers it in a first-word-fall-through FIFO. The FIFO drains toward a single sink over a valid/ready handshake. It also returns a one-cycle ack to the captured source so that source drops its request, and flags illegal (non-one-hot) grants.

## Interface
- DW, 8, data word width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- gnt  in  3  one-hot grant from the arbiter; bit 0 = source 0
- src_data0 / src_data1 / src_data2  in  DW each  source data words, valid while that source is granted
- src_ack  out  3  one-cycle ack per source: word captured
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  sink accepts the head word
- out_data  out  DW  head word
- out_src  out  2  source ID of the head word: 0, 1 or 2
- count  out  $clog2(DEPTH+1)  current occupancy
- full  out  1  count == DEPTH
- gnt_err  out  1  sticky illegal-grant flag

## Operation
- **Grant decode**
  - Legal grant: gnt is exactly one of 001, 010 or 100. Encoded ID k is 0, 1 or 2.
  - gnt = 000 is idle.
  - Any other gnt value sets gnt_err, which stays set until reset. The grant is treated as idle for that cycle.
- **Capture FSM**
  - States are IDLE and HOLD. HOLD also stores last_k, the ID of the source captured most recently.
  - space = (count < DEPTH) || pop.
  - pop = out_valid && out_ready.
  - IDLE:
    - Legal grant and space: capture, set last_k = k, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD:
    - gnt == 000: go to IDLE. No capture.
    - Illegal grant: go to IDLE. No capture.
    - Legal grant with k == last_k: no capture. The source's request has not yet propagated through the arbiter; this rule blocks duplicate captures.
    - Legal grant with k != last_k and space: capture, set last_k = k, stay in HOLD.
    - Legal grant with k != last_k and no space: stay in HOLD with the old last_k, and retry each cycle.
- **Capture action**
  - Push {k, src_data_k} into the FIFO.
  - Set src_ack[k] = 1 on the next cycle, for exactly one cycle. All other ack bits are 0.
- **Full FIFO**
  - No capture and no ack. The grant stays pending, and the source keeps its request asserted.
- **FIFO**
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH.
  - out_data and out_src come combinationally from the entry at the read pointer.
  - Pop with out_valid = 0 is ignored. When empty, out_data and out_src are don't-care.
  - Simultaneous push and pop: count is unchanged. This is legal at full and at empty+1.
  - At full with out_ready = 1, push and pop occur in the same cycle.
- **Reset values**
  - src_ack = 0, out_valid = 0, count = 0, full = 0, gnt_err = 0.
  - State = IDLE, last_k = 0, both pointers = 0.
- **Reset mid-operation**
  - FIFO contents are discarded, and any pending ack is cancelled.

## Timing
- gnt is sampled at edge T. On capture:
  - The entry becomes visible at T+1: out_valid rises if the FIFO was empty.
  - src_ack[k] is high during T+1 → T+2.
  - Capture-to-out_valid latency is 1 cycle.
- The earliest recapture from the same source is the first cycle its grant reappears after a gnt change. With the arbiter's registered grant, back-to-back words from one source need at least 3 cycles.
- gnt_err rises at T+1 after the illegal sample.
- Throughput: one capture per cycle when grants alternate between sources and the sink is always ready.
- The FSM-to-pop path uses out_ready combinationally. src_ack is fully registered.

## Structure
- Package arb_pkg holds:
  - NUM_SRC = 3
  - SRC_ID_W = 2
  - the capture-state enum (CAP_IDLE, CAP_HOLD)
  - the one-hot-to-ID function with its legality check
- The arbiter reuses NUM_SRC from the same package.
- Sub-module sync_fifo_fwft has parameters W = DW + 2 and DEPTH. Its ports are push/pop/din/dout/count/full/empty.
- The capture FSM, the ack register and gnt_err live in the top level.

## Test plan
- **Single capture:** gnt=001 held for 3 cycles, src_data0=0x5A → exactly one push and one src_ack[0] pulse; out_src=0, out_data=0x5A; count=1.
- **Alternating grants:** gnt 001, 010, 100 on consecutive cycles, data 0x11/0x22/0x33, out_ready=0 → three acks on successive cycles; count=3; drains in order 0x11, 0x22, 0x33 with IDs 0, 1, 2.
- **Full blocking:** DEPTH=4 filled, out_ready=0, gnt=010 held → no ack, count stays 4. Then out_ready=1 for 1 cycle → pop and capture in the same cycle; count stays 4; src_ack[1] pulses.
- **Illegal grant:** gnt=011 for 1 cycle → gnt_err=1 from the next cycle onward; no push. A later legal gnt=100 is captured normally, and gnt_err stays 1.
- **Same-source recapture:** gnt 001 → 000 → 001 → two captures, two acks. gnt 001 held continuously → one capture only.
- **Reset mid-operation:** rst_n low while count=2 and an ack is pending → count=0, out_valid=0 and src_ack=0 immediately; state IDLE after release.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter and its grant-capture consumer.
package arb_pkg;

    localparam int unsigned NUM_SRC  = 3;
    localparam int unsigned SRC_ID_W = 2;

    typedef enum logic [0:0] {
        CAP_IDLE,
        CAP_HOLD
    } cap_state_e;

    typedef struct packed {
        logic                legal;
        logic [SRC_ID_W-1:0] id;
    } gnt_dec_t;

    // Exactly one bit set is legal; zero and multi-hot both come back illegal.
    function automatic gnt_dec_t decode_gnt(input logic [NUM_SRC-1:0] g);
        gnt_dec_t d;
        d.legal = 1'b1;
        d.id    = '0;
        case (g)
            3'b001:  d.id = 2'd0;
            3'b010:  d.id = 2'd1;
            3'b100:  d.id = 2'd2;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arb_grant_capture_if.sv
// Grant/data inputs from the arbiter side plus the FIFO drain handshake.
interface arb_grant_capture_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
);
    import arb_pkg::*;

    logic [NUM_SRC-1:0]           gnt;
    logic [DW-1:0]                src_data0;
    logic [DW-1:0]                src_data1;
    logic [DW-1:0]                src_data2;
    logic [NUM_SRC-1:0]           src_ack;
    logic                         out_valid;
    logic                         out_ready;
    logic [DW-1:0]                out_data;
    logic [SRC_ID_W-1:0]          out_src;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         gnt_err;

    // Capture block side
    modport slave (
        input  gnt, src_data0, src_data1, src_data2, out_ready,
        output src_ack, out_valid, out_data, out_src, count, full, gnt_err
    );

    // Arbiter/sources/sink side
    modport master (
        output gnt, src_data0, src_data1, src_data2, out_ready,
        input  src_ack, out_valid, out_data, out_src, count, full, gnt_err
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head entry is always visible on dout.
module sync_fifo_fwft #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    // Pop on empty is ignored; a push at full is allowed only alongside a pop.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= din;
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem[rptr_q];

endmodule

// File: rtl/arb_grant_capture.sv
// Captures one tagged word per grant episode into a FWFT FIFO, acks the source,
// and flags non-one-hot grants.
module arb_grant_capture
    import arb_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    arb_grant_capture_if.slave  bus
);
    localparam int unsigned W  = DW + SRC_ID_W;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    cap_state_e          state;
    logic [SRC_ID_W-1:0] last_k;
    logic [NUM_SRC-1:0]  ack;
    logic                err;

    gnt_dec_t            dec;
    logic                illegal;
    logic                pop, space, capture;
    logic [DW-1:0]       sel_data;
    logic [W-1:0]        fifo_dout;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full, fifo_empty;

    // Grant decode, sink handshake and capture decision.
    always_comb begin
        dec     = decode_gnt(bus.gnt);
        illegal = (bus.gnt != '0) && !dec.legal;
        pop     = !fifo_empty && bus.out_ready;
        space   = !fifo_full || pop;
        capture = 1'b0;
        unique case (state)
            CAP_IDLE: capture = dec.legal && space;
            // Same ID as last capture means the source has not dropped its request yet.
            CAP_HOLD: capture = dec.legal && (dec.id != last_k) && space;
            default:  capture = 1'b0;
        endcase
    end

    // Select the granted source's data word.
    always_comb begin
        sel_data = '0;
        case (dec.id)
            2'd0:    sel_data = bus.src_data0;
            2'd1:    sel_data = bus.src_data1;
            2'd2:    sel_data = bus.src_data2;
            default: sel_data = '0;
        endcase
    end

    // Capture FSM with registered ack and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CAP_IDLE;
            last_k <= '0;
            ack    <= '0;
            err    <= 1'b0;
        end else begin
            err <= err | illegal;
            ack <= capture ? (NUM_SRC'(1) << dec.id) : '0;
            if (capture) last_k <= dec.id;
            case (state)
                CAP_IDLE: if (capture)    state <= CAP_HOLD;
                CAP_HOLD: if (!dec.legal) state <= CAP_IDLE;
                default:                  state <= CAP_IDLE;
            endcase
        end
    end

    sync_fifo_fwft #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .pop   (pop),
        .din   ({dec.id, sel_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.src_ack   = ack;
    assign bus.gnt_err   = err;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_dout[DW-1:0];
    assign bus.out_src   = fifo_dout[W-1:DW];
    assign bus.count     = fifo_count;
    assign bus.full      = fifo_full;

endmodule
